noc_inject_arbiter: RTL and testbench
=====================================

Name: noc_inject_arbiter

Overview:
- Round-robin arbiter sharing one 64-bit NoC injection FIFO among N_REQ AXI4-lite slave front-ends. Each slave presents {awaddr, wdata} packets.
- Sits between the slaves' FIFO write side and the FIFO write port.
- Registers the winning packet into the FIFO with one-cycle latency.
- Applies full/almost-full backpressure to all requesters.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 64, packet width ({addr[31:0], data[31:0]}).
- MAX_BURST, 4, maximum consecutive grants to one requester; used only with NOC_ARB_BURST_EN.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- arestn  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester packet valid.
- req_data  in  N_REQ*DATA_W  packets; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester accept (combinational, one-hot or zero).
- fifo_write_en  out  1  FIFO write strobe (registered).
- fifo_write_data  out  DATA_W  FIFO write data (registered).
- fifo_full  in  1  FIFO full.
- fifo_almost_full  in  1  FIFO has exactly one free entry.
- grant_id  out  $clog2(N_REQ)  index of the requester written on the current fifo_write_en (registered).
- busy  out  1  high when any req_valid is set or fifo_write_en is high.

Behaviour:
- Reset (arestn low, asynchronous):
  - fifo_write_en=0, fifo_write_data=0, grant_id=0.
  - Round-robin pointer rr_ptr=0; burst counter=0; state=IDLE.
  - req_ready=0 while in reset.
  - A beat accepted in the cycle reset asserts is dropped, not written.
- Accept condition: can_accept = !fifo_full && !(fifo_write_en && fifo_almost_full). This covers the one in-flight registered write.
- Selection:
  - When can_accept, sel = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[sel]=1 in the same cycle; all other bits 0.
  - When nothing is valid or !can_accept, req_ready=0.
- Transfer: occurs when req_valid[sel] && req_ready[sel]. On the next edge:
  - fifo_write_en<=1, fifo_write_data<=req_data[sel], grant_id<=sel.
  - rr_ptr<=(sel+1) mod N_REQ, wrapping N_REQ-1 -> 0.
- No transfer: on that edge fifo_write_en<=0; fifo_write_data and grant_id hold.
- Latency: exactly 1 cycle from handshake to fifo_write_en. Throughput is 1 packet/cycle while can_accept holds.
- Requester rule: once req_valid[i] rises, it and its data must be held until req_ready[i]. The arbiter never depends on a valid being withdrawn.
- Fairness: with all N_REQ requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 grants.
- Simultaneous events:
  - fifo_full and a new req_valid in the same cycle: no accept; pointer unchanged.
  - A single active requester is granted every accepting cycle.
- busy is combinational: |req_valid || fifo_write_en.

Optional Feature:
- Macro: NOC_ARB_BURST_EN.
- With the macro, FSM states IDLE/BURST:
  - After a transfer from requester i, enter BURST with owner=i and count=1.
  - In BURST, sel=owner while req_valid[owner] && count<MAX_BURST.
  - Each transfer increments count.
  - On owner invalid or count==MAX_BURST: return to IDLE, set rr_ptr=owner+1 mod N_REQ, and run a normal round-robin pick that same cycle.
  - A backpressure stall keeps BURST; count is not incremented.
- Without the macro: no FSM or counter; pure per-beat round-robin as above.

Decomposition:
- Shared package noc_pkg:
  - NOC_PKT_W=64 and packet field offsets (ADDR at [63:32], DATA at [31:0]).
  - Arbiter state encoding (ARB_IDLE, ARB_BURST).
- One sub-module: noc_rr_picker, a combinational rotate-priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and index.

Test Plan:
- Reset then idle: hold arestn=0 for 3 cycles, release; all req_valid=0 -> fifo_write_en=0, req_ready=0, busy=0, grant_id=0.
- Single requester: req_valid=4'b0100, data 64'hA000_0010_DEAD_BEEF -> req_ready=4'b0100 in the same cycle; next cycle fifo_write_en=1, data matches, grant_id=2.
- All four valid continuously, 8 transfers -> grant_id sequence 0,1,2,3,0,1,2,3; no gaps in fifo_write_en.
- Backpressure, two cases:
  - fifo_full=1 for 3 cycles with requesters 1 and 3 valid -> req_ready=0 and no writes; on release, 1 is granted then 3.
  - fifo_almost_full=1 with fifo_write_en=1 -> req_ready=0 that cycle.
- Async reset mid-stream: drop arestn between clock edges during back-to-back transfers -> fifo_write_en falls immediately, no edge needed; after release, arbitration restarts at requester 0.
- NOC_ARB_BURST_EN with MAX_BURST=4 and requesters 0 and 1 always valid -> grants 0,0,0,0,1,1,1,1,0; a mid-burst deassertion of req_valid[0] after 2 beats hands the grant to 1 in the same cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC packet layout and injection arbiter state encoding
package noc_pkg;

    localparam int NOC_PKT_W     = 64;
    localparam int NOC_FIELD_W   = 32;
    localparam int NOC_ADDR_LSB  = 32;
    localparam int NOC_ADDR_MSB  = 63;
    localparam int NOC_DATA_LSB  = 0;
    localparam int NOC_DATA_MSB  = 31;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_rr_picker.sv
// rtl/noc_rr_picker.sv - combinational rotate-priority encoder starting at i_ptr
module noc_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan i_ptr, i_ptr+1, ... modulo N_REQ and take the first active request
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(i_ptr) + k) % N_REQ;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - round-robin arbiter into the NoC injection FIFO; NOC_ARB_BURST_EN adds burst ownership
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = NOC_PKT_W
`ifdef NOC_ARB_BURST_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input  logic                     aclk,
    input  logic                     arestn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     fifo_write_en,
    output logic [DATA_W-1:0]        fifo_write_data,
    input  logic                     fifo_full,
    input  logic                     fifo_almost_full,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_REQ);

    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic [IDX_W-1:0]  r_grant_id;
    logic [IDX_W-1:0]  r_rr_ptr;

    logic              w_can_accept;
    logic [N_REQ-1:0]  w_pick_grant;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic [N_REQ-1:0]  w_sel_grant;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_sel_any;
    logic              w_xfer;
    logic [IDX_W-1:0]  w_next_ptr;

    // The registered write still in flight consumes the last free entry when almost full
    assign w_can_accept = !fifo_full && !(r_wr_en && fifo_almost_full);

    noc_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

`ifdef NOC_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_count;
    logic             w_hold;

    // Burst state register
    always_ff @(posedge aclk or negedge arestn) begin
        if (!arestn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner keeps the grant until it drops valid or uses up its burst; otherwise round-robin
    always_comb begin
        w_hold       = (r_state == ARB_BURST) && req_valid[r_owner] &&
                       (r_count < CNT_W'(MAX_BURST));
        w_sel_any    = w_pick_any;
        w_sel_idx    = w_pick_idx;
        w_sel_grant  = w_pick_grant;
        w_next_state = r_state;
        if (w_hold) begin
            w_sel_any   = 1'b1;
            w_sel_idx   = r_owner;
            w_sel_grant = N_REQ'(1) << r_owner;
        end
        if (w_can_accept && (w_hold || w_pick_any)) begin
            w_next_state = ARB_BURST;
        end else if (!w_hold) begin
            w_next_state = ARB_IDLE;
        end
    end

    // Track burst owner and beats granted; a stall leaves both untouched
    always_ff @(posedge aclk or negedge arestn) begin
        if (!arestn) begin
            r_owner <= '0;
            r_count <= '0;
        end else if (w_xfer) begin
            if (w_hold) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_owner <= w_sel_idx;
                r_count <= CNT_W'(1);
            end
        end
    end
`else
    assign w_sel_any   = w_pick_any;
    assign w_sel_idx   = w_pick_idx;
    assign w_sel_grant = w_pick_grant;
`endif

    assign req_ready  = (arestn && w_can_accept && w_sel_any) ? w_sel_grant : '0;
    assign w_xfer     = |req_ready;
    assign w_next_ptr = (w_sel_idx == IDX_W'(N_REQ - 1)) ? '0 : w_sel_idx + IDX_W'(1);

    // Register the winning packet into the FIFO and advance the round-robin pointer
    always_ff @(posedge aclk or negedge arestn) begin
        if (!arestn) begin
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_data  <= req_data[int'(w_sel_idx)*DATA_W +: DATA_W];
                r_grant_id <= w_sel_idx;
                r_rr_ptr   <= w_next_ptr;
            end
        end
    end

    assign fifo_write_en   = r_wr_en;
    assign fifo_write_data = r_wr_data;
    assign grant_id        = r_grant_id;
    assign busy            = (|req_valid) || r_wr_en;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - directed self-checking bench for noc_inject_arbiter
module tb_noc_inject_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic          aclk = 1'b0;
    logic          arestn;
    logic [N-1:0]  req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_write_en;
    logic [W-1:0]  fifo_write_data;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic [1:0]    grant_id;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    noc_inject_arbiter #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .aclk             (aclk),
        .arestn           (arestn),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_write_en    (fifo_write_en),
        .fifo_write_data  (fifo_write_data),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] pkt_of(input int i);
        return {32'hA000_0000 + 32'(i << 4), 32'hC0DE_0000 + 32'(i)};
    endfunction

    function automatic int all4_seq(input int k);
`ifdef NOC_ARB_BURST_EN
        return (k / 4) % 2;
`else
        return k % 4;
`endif
    endfunction

    task automatic load_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = pkt_of(i);
    endtask

    task automatic do_reset();
        arestn           = 1'b0;
        req_valid        = '0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        load_data();
        repeat (3) @(posedge aclk);
        #1 arestn = 1'b1;
    endtask

    initial begin
        // reset with requests pending, then idle
        arestn = 1'b0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        load_data();
        req_valid = 4'hF;
        @(negedge aclk);
        check("rst_ready", req_ready, 0);
        check("rst_wr_en", fifo_write_en, 0);
        check("rst_data", fifo_write_data, 0);
        req_valid = '0;
        repeat (2) @(posedge aclk);
        #1 arestn = 1'b1;
        @(negedge aclk);
        check("idle_wr_en", fifo_write_en, 0);
        check("idle_ready", req_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_gid", grant_id, 0);

        // all four valid continuously
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k <= 8; k++) begin
            @(negedge aclk);
            if (k < 8) check($sformatf("all4_ready%0d", k), req_ready, 4'b0001 << all4_seq(k));
            else       check("all4_ready_end", req_ready, 0);
            if (k > 0) begin
                check($sformatf("all4_wr_en%0d", k), fifo_write_en, 1);
                check($sformatf("all4_gid%0d", k), grant_id, all4_seq(k - 1));
                check($sformatf("all4_data%0d", k), fifo_write_data, pkt_of(all4_seq(k - 1)));
            end
            if (k == 7) begin
                @(posedge aclk);
                #1 req_valid = '0;
            end
        end

        // fifo_full backpressure with requesters 1 and 3
        do_reset();
        fifo_full = 1'b1;
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check($sformatf("full_ready%0d", k), req_ready, 0);
            check($sformatf("full_wr_en%0d", k), fifo_write_en, 0);
        end
        @(posedge aclk);
        #1 fifo_full = 1'b0;
        @(negedge aclk);
        check("full_rel_ready", req_ready, 4'b0010);
        check("full_rel_wr_en", fifo_write_en, 0);
        @(posedge aclk);
        #1 req_valid = 4'b1000;
        @(negedge aclk);
        check("full_g1_wr_en", fifo_write_en, 1);
        check("full_g1_gid", grant_id, 1);
        check("full_g1_data", fifo_write_data, pkt_of(1));
        check("full_g3_ready", req_ready, 4'b1000);
        @(posedge aclk);
        #1 req_valid = '0;
        @(negedge aclk);
        check("full_g3_gid", grant_id, 3);
        check("full_g3_data", fifo_write_data, pkt_of(3));
        @(posedge aclk);
        @(negedge aclk);
        check("full_end_wr_en", fifo_write_en, 0);
        check("full_end_gid_hold", grant_id, 3);

        // single requester, then almost-full with a write in flight
        do_reset();
        req_data[2*W +: W] = 64'hA000_0010_DEAD_BEEF;
        req_valid = 4'b0100;
        @(negedge aclk);
        check("single_ready", req_ready, 4'b0100);
        check("single_busy", busy, 1);
        @(posedge aclk);
        #1 req_valid = 4'b0001;
        fifo_almost_full = 1'b1;
        @(negedge aclk);
        check("single_wr_en", fifo_write_en, 1);
        check("single_data", fifo_write_data, 64'hA000_0010_DEAD_BEEF);
        check("single_gid", grant_id, 2);
        check("af_ready_blocked", req_ready, 0);
        @(posedge aclk);
        @(negedge aclk);
        check("af_wr_en_gap", fifo_write_en, 0);
        check("af_ready_open", req_ready, 4'b0001);
        @(posedge aclk);
        #1 req_valid = '0;
        fifo_almost_full = 1'b0;
        @(negedge aclk);
        check("af_g0_wr_en", fifo_write_en, 1);
        check("af_g0_gid", grant_id, 0);
        check("af_g0_data", fifo_write_data, pkt_of(0));
        load_data();

        // asynchronous reset during back-to-back writes
        do_reset();
        req_valid = 4'b0100;
        @(posedge aclk);
        @(negedge aclk);
        check("ar_b2b_wr_en1", fifo_write_en, 1);
        @(posedge aclk);
        @(negedge aclk);
        check("ar_b2b_wr_en2", fifo_write_en, 1);
        check("ar_b2b_gid", grant_id, 2);
        #2 arestn = 1'b0;
        #1;
        check("ar_wr_en_drop", fifo_write_en, 0);
        check("ar_ready_drop", req_ready, 0);
        check("ar_gid_clear", grant_id, 0);
        req_valid = 4'hF;
        @(posedge aclk);
        #1 arestn = 1'b1;
        @(negedge aclk);
        check("ar_restart_ready", req_ready, 4'b0001);
        @(posedge aclk);
        #1 req_valid = '0;
        @(negedge aclk);
        check("ar_restart_gid", grant_id, 0);
        check("ar_restart_wr_en", fifo_write_en, 1);

`ifdef NOC_ARB_BURST_EN
        // bursts of four between requesters 0 and 1, then an early owner drop
        begin
            int bseq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
            do_reset();
            req_valid = 4'b0011;
            for (int k = 0; k < 10; k++) begin
                @(negedge aclk);
                check($sformatf("burst_ready%0d", k), req_ready, 4'b0001 << bseq[k]);
                if (k > 0) begin
                    check($sformatf("burst_wr_en%0d", k), fifo_write_en, 1);
                    check($sformatf("burst_gid%0d", k), grant_id, bseq[k - 1]);
                end
            end
            @(posedge aclk);
            #1 req_valid = 4'b0010;
            @(negedge aclk);
            check("burst_drop_ready", req_ready, 4'b0010);
            check("burst_drop_gid", grant_id, 0);
            @(posedge aclk);
            #1 req_valid = '0;
            @(negedge aclk);
            check("burst_drop_g1", grant_id, 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
